// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing controller for an approximate shift-add multiplier.
// One operand pair per transaction; the multiplier is walked one bit per clock
// after its lowest approx_lvl bits are dropped. Walking stops early once no
// set multiplier bits remain, so latency tracks the highest set bit.
module mul_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int LVLW  = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [LVLW-1:0]    approx_lvl,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [LVLW-1:0] WIDTH_L = LVLW'(WIDTH);
   localparam logic [LVLW-1:0] ONE_L   = {{(LVLW-1){1'b0}}, 1'b1};

   // Partial-product cell: the multiplicand gated by a single multiplier bit.
   function automatic logic [2*WIDTH-1:0] pp_gate(input logic [2*WIDTH-1:0] mcand,
                                                  input logic               mbit);
      pp_gate = mcand & {(2*WIDTH){mbit}};
   endfunction

   logic [1:0]           state_q,     state_d;
   logic [2*WIDTH-1:0]   acc_q,       acc_d;
   logic [2*WIDTH-1:0]   a_q,         a_d;
   logic [WIDTH-1:0]     b_q,         b_d;
   logic [LVLW-1:0]      cnt_q,       cnt_d;
   logic [2*WIDTH-1:0]   product_q,   product_d;
   logic                 in_ready_q,  in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q,      busy_d;

   logic [LVLW-1:0]      lvl_eff_s;
   logic [WIDTH-1:0]     b_shift_s;
   logic [2*WIDTH-1:0]   a_shift_s;
   logic [2*WIDTH-1:0]   acc_sum_s;

   // Clamp the approximation level to WIDTH and pre-align the operands for accept.
   always_comb begin
      if (approx_lvl > WIDTH_L) begin
         lvl_eff_s = WIDTH_L;
      end else begin
         lvl_eff_s = approx_lvl;
      end
      b_shift_s = b >> lvl_eff_s;
      a_shift_s = {{WIDTH{1'b0}}, a} << lvl_eff_s;
      acc_sum_s = acc_q + pp_gate(a_q, b_q[0]);
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d   = a_shift_s;
               b_d   = b_shift_s;
               cnt_d = WIDTH_L - lvl_eff_s;
               acc_d = {(2*WIDTH){1'b0}};
               if (b_shift_s == {WIDTH{1'b0}}) begin
                  // Nothing left to multiply: the product is zero, skip RUN.
                  state_d   = S_DONE;
                  product_d = {(2*WIDTH){1'b0}};
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = acc_sum_s;
            a_d   = a_q << 1'b1;
            b_d   = b_q >> 1'b1;
            cnt_d = cnt_q - ONE_L;
            // Leave on the last bit or as soon as the remaining bits are all zero.
            if ((cnt_q == ONE_L) || ((b_q >> 1'b1) == {WIDTH{1'b0}})) begin
               state_d   = S_DONE;
               product_d = acc_sum_s;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output flags decoded from the next state so they can be registered.
   always_comb begin
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
   end

   // State, datapath and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= {(2*WIDTH){1'b0}};
         a_q         <= {(2*WIDTH){1'b0}};
         b_q         <= {WIDTH{1'b0}};
         cnt_q       <= {LVLW{1'b0}};
         product_q   <= {(2*WIDTH){1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         product_q   <= product_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl (WIDTH=8): expected products and RUN lengths are
// computed when operands are driven, queued, and compared when out_valid rises.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [3:0]  approx_lvl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   typedef struct {
      logic [15:0] prod;
      int          k;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   mul_seq_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .approx_lvl(approx_lvl), .out_valid(out_valid),
      .out_ready(out_ready), .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
   task automatic drive_op(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] lv);
      exp_t       e;
      int         l;
      logic [7:0] bm;
      l  = (lv > 4'd8) ? 8 : int'(lv);
      bm = bv;
      for (int i = 0; i < l; i++) bm[i] = 1'b0;
      e.prod = 16'(av) * 16'(bm);
      e.k    = 0;
      for (int i = l; i < 8; i++) if (bv[i]) e.k = i - l + 1;
      sb_q.push_back(e);
      in_valid   = 1'b1;
      a          = av;
      b          = bv;
      approx_lvl = lv;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts negedges until out_valid; a stuck DUT yields 200, which no latency matches.
   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 8'd0; b = 8'd0; approx_lvl = 4'd0;
      #12;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (product !== 16'd0) begin n_err++; $display("FAIL reset_product: got %0d want 0", product); end
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
   endtask

   task automatic test_full;
      exp_t e; int c;
      drive_op(8'd200, 8'd255, 4'd0);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready_low: got %b want 0", in_ready); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", busy); end
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== 8) begin n_err++; $display("FAIL full_latency: got %0d want 8", c); end
      n_vec++; if (product !== 16'd51000) begin n_err++; $display("FAIL full_product: got %0d want 51000", product); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_one_cycle: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_back_idle: got %b want 1", in_ready); end
   endtask

   task automatic test_approx;
      exp_t e; int c;
      drive_op(8'd200, 8'd255, 4'd4);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== e.k) begin n_err++; $display("FAIL approx_latency: got %0d want %0d", c, e.k); end
      n_vec++; if (product !== 16'd48000) begin n_err++; $display("FAIL approx_product: got %0d want 48000", product); end
      @(negedge clk);
      drive_op(8'd37, 8'd3, 4'd0);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== 2) begin n_err++; $display("FAIL early_latency: got %0d want 2", c); end
      n_vec++; if (product !== e.prod) begin n_err++; $display("FAIL early_product: got %0d want %0d", product, e.prod); end
      @(negedge clk);
   endtask

   task automatic test_zero_skip;
      exp_t e; int c;
      drive_op(8'd99, 8'd15, 4'd4);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== 0) begin n_err++; $display("FAIL skip_latency: got %0d want 0", c); end
      n_vec++; if (product !== 16'd0) begin n_err++; $display("FAIL skip_product: got %0d want 0", product); end
      @(negedge clk);
      drive_op(8'd3, 8'd5, 4'd0);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (product !== 16'd15) begin n_err++; $display("FAIL small_product: got %0d want 15", product); end
      @(negedge clk);
      drive_op(8'd99, 8'd255, 4'd9);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== 0) begin n_err++; $display("FAIL clamp_latency: got %0d want 0", c); end
      n_vec++; if (product !== 16'd0) begin n_err++; $display("FAIL clamp_product: got %0d want 0", product); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      exp_t e; int c;
      out_ready = 1'b0;
      drive_op(8'd17, 8'd129, 4'd0);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== 8) begin n_err++; $display("FAIL bp_latency: got %0d want 8", c); end
      n_vec++; if (product !== 16'd2193) begin n_err++; $display("FAIL bp_product: got %0d want 2193", product); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255)); approx_lvl = 4'd0;
         @(negedge clk);
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
         n_vec++; if (product !== 16'd2193) begin n_err++; $display("FAIL bp_hold_product[%0d]: got %0d want 2193", i, product); end
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_idle: got %b want 1", in_ready); end
      n_vec++; if (product !== 16'd2193) begin n_err++; $display("FAIL bp_keep_product: got %0d want 2193", product); end
      drive_op(8'd11, 8'd13, 4'd0);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== e.k) begin n_err++; $display("FAIL bp_next_latency: got %0d want %0d", c, e.k); end
      n_vec++; if (product !== 16'd143) begin n_err++; $display("FAIL bp_next_product: got %0d want 143", product); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      exp_t e; int c;
      drive_op(8'd255, 8'd255, 4'd0);
      @(negedge clk); @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle: got %b want 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      n_vec++; if (product !== 16'd0) begin n_err++; $display("FAIL mid_rst_product: got %0d want 0", product); end
      sb_q.delete();
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_output: got %b want 0", out_valid); end
      drive_op(8'd2, 8'd3, 4'd0);
      wait_out(c); e = sb_q.pop_front();
      n_vec++; if (c !== 2) begin n_err++; $display("FAIL mid_after_latency: got %0d want 2", c); end
      n_vec++; if (product !== 16'd6) begin n_err++; $display("FAIL mid_after_product: got %0d want 6", product); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      exp_t e; int c;
      logic [7:0] ta [0:3] = '{8'd5, 8'd255, 8'd128, 8'd0};
      logic [7:0] tb [0:3] = '{8'd200, 8'd1, 8'd128, 8'd77};
      logic [3:0] tl [0:3] = '{4'd1, 4'd0, 4'd7, 4'd2};
      for (int i = 0; i < 10; i++) begin
         if (i < 4) drive_op(ta[i], tb[i], tl[i]);
         else drive_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 9)));
         wait_out(c); e = sb_q.pop_front();
         n_vec++; if (c !== e.k) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, c, e.k); end
         n_vec++; if (product !== e.prod) begin n_err++; $display("FAIL b2b_product[%0d]: got %0d want %0d", i, product, e.prod); end
         @(negedge clk);
         n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      end
   endtask

   initial begin
      test_reset;
      test_full;
      test_approx;
      test_zero_skip;
      test_backpressure;
      test_reset_mid_run;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
